irq_ctrl: RTL and testbench

Parametrised interrupt front-end for the pipelined MIPS core. It replaces the single raw `IRQ` input of the instruction decoder with a NUM_IRQ-channel block that provides pending latches, a software mask, and fixed priority. It emits a one-shot, stall-aware `irq_take` request, which the decoder uses to substitute the IRQ control word (PCSrc=100, RegDst=11, MemtoReg=11). The block sits beside the decoder in ID and tracks handler entry and exit through the supervisor bit of the ID-stage PC.

---
 rtl/irq_ctrl.sv | 135 +++++++++++++
 tb/tb_irq_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// Interrupt front-end for the ID stage: pending latches, mask, fixed priority, one-shot take.
// Define IRQ_EDGE_EN for edge-triggered sticky pending with ack; default build is level mode.
module irq_ctrl #(
  parameter int unsigned NUM_IRQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               irq_mask_wr,
  input  logic [NUM_IRQ-1:0] irq_mask_wdata,
  input  logic               irq_ack,
  input  logic [ID_W-1:0]    irq_ack_id,
  input  logic               pc_super,
  input  logic               stall,
  output logic               irq_take,
  output logic [ID_W-1:0]    irq_id,
  output logic               irq_active,
  output logic [NUM_IRQ-1:0] irq_pending,
  output logic [NUM_IRQ-1:0] irq_mask
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ENTER,
    IN_HANDLER
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] elig;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    win_id;
  logic               win_vld;

`ifdef IRQ_EDGE_EN
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] ack_clr;

  // Out-of-range ack ids match no channel; a new edge beats a same-cycle ack.
  always_comb begin
    ack_clr = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      ack_clr[i] = irq_ack && (32'(irq_ack_id) == i);
    end
    pend_d = (pend_q & ~ack_clr) | (irq_in & ~irq_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q <= '0;
    end else begin
      irq_q <= irq_in;
    end
  end
`else
  logic unused_ack;
  assign unused_ack = ^{irq_ack, irq_ack_id};

  always_comb begin
    pend_d = irq_in;
  end
`endif

  always_comb begin
    mask_d = irq_mask_wr ? irq_mask_wdata : mask_q;
  end

  assign elig = pend_q & mask_q;

  always_comb begin
    win_id  = '0;
    win_vld = 1'b0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (elig[i] && !win_vld) begin
        win_id  = ID_W'(i);
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (win_vld && !pc_super) begin
          state_d = ISSUE;
          id_d    = win_id;
        end
      end
      ISSUE: begin
        if (!stall) begin
          state_d = WAIT_ENTER;
        end
      end
      WAIT_ENTER: begin
        if (pc_super) begin
          state_d = IN_HANDLER;
        end
      end
      IN_HANDLER: begin
        if (!pc_super) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= '0;
      mask_q  <= '1;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      id_q    <= id_d;
    end
  end

  assign irq_take    = (state_q == ISSUE);
  assign irq_active  = (state_q != IDLE);
  assign irq_id      = id_q;
  assign irq_pending = pend_q;
  assign irq_mask    = mask_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: stimulus pushes expected takes, a negedge monitor checks them.
// Covers both the default level build and the IRQ_EDGE_EN build.
module tb_irq_ctrl;

  localparam int unsigned NUM_IRQ = 4;
  localparam int unsigned ID_W    = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic [NUM_IRQ-1:0] irq_in;
  logic               irq_mask_wr;
  logic [NUM_IRQ-1:0] irq_mask_wdata;
  logic               irq_ack;
  logic [ID_W-1:0]    irq_ack_id;
  logic               pc_super;
  logic               stall;
  logic               irq_take;
  logic [ID_W-1:0]    irq_id;
  logic               irq_active;
  logic [NUM_IRQ-1:0] irq_pending;
  logic [NUM_IRQ-1:0] irq_mask;

  irq_ctrl #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .irq_in         (irq_in),
    .irq_mask_wr    (irq_mask_wr),
    .irq_mask_wdata (irq_mask_wdata),
    .irq_ack        (irq_ack),
    .irq_ack_id     (irq_ack_id),
    .pc_super       (pc_super),
    .stall          (stall),
    .irq_take       (irq_take),
    .irq_id         (irq_id),
    .irq_active     (irq_active),
    .irq_pending    (irq_pending),
    .irq_mask       (irq_mask)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned id;
    int unsigned at;
    int unsigned len;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic push(int unsigned id, int unsigned at, int unsigned len);
    exp_t e;
    e.id  = id;
    e.at  = at;
    e.len = len;
    sb.push_back(e);
  endtask

  // Monitor: a rising take pops the scoreboard; the falling edge checks duration.
  bit          mon_in_take = 1'b0;
  bit          mon_have    = 1'b0;
  int unsigned mon_start   = 0;
  exp_t        mon_cur;

  always @(negedge clk) begin
    if (irq_take === 1'b1 && !mon_in_take) begin
      mon_in_take = 1'b1;
      mon_start   = cyc;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        mon_have = 1'b0;
        $display("FAIL unexpected_take: got take id %0d expected no take (cycle %0d)", irq_id, cyc);
      end else begin
        mon_cur  = sb.pop_front();
        mon_have = 1'b1;
        chk("take_id", 32'(irq_id), mon_cur.id);
        chk("take_cycle", cyc, mon_cur.at);
      end
    end else if (irq_take !== 1'b1 && mon_in_take) begin
      mon_in_take = 1'b0;
      if (mon_have) chk("take_len", cyc - mon_start, mon_cur.len);
      mon_have = 1'b0;
    end
  end

  task automatic tick(int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called in WAIT_ENTER: enter handler, service the source, return to IDLE.
  task automatic finish_handler(int unsigned id);
    pc_super   = 1'b1;
    irq_in[id] = 1'b0;
`ifdef IRQ_EDGE_EN
    irq_ack    = 1'b1;
    irq_ack_id = ID_W'(id);
`endif
    tick(1);
    chk("handler_active", 32'(irq_active), 1);
    irq_ack  = 1'b0;
    pc_super = 1'b0;
    tick(1);
    chk("handler_exit_active", 32'(irq_active), 0);
  endtask

  int unsigned e0;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    irq_in         = '0;
    irq_mask_wr    = 1'b0;
    irq_mask_wdata = '0;
    irq_ack        = 1'b0;
    irq_ack_id     = '0;
    pc_super       = 1'b0;
    stall          = 1'b0;
    tick(2);
    chk("rst_take", 32'(irq_take), 0);
    chk("rst_active", 32'(irq_active), 0);
    chk("rst_id", 32'(irq_id), 0);
    chk("rst_pending", 32'(irq_pending), 0);
    chk("rst_mask", 32'(irq_mask), 4'b1111);
    reset = 1'b0;
    tick(2);

    // Two lines together: ch1 first, ch2 after the handler returns.
    irq_in = 4'b0110;
    e0 = cyc;
    push(1, e0 + 2, 1);
    tick(1);
    chk("a_pending", 32'(irq_pending), 4'b0110);
    chk("a_no_take_yet", 32'(irq_take), 0);
    tick(1);
    chk("a_take", 32'(irq_take), 1);
    chk("a_active", 32'(irq_active), 1);
    tick(1);
    chk("a_take_done", 32'(irq_take), 0);
    chk("a_wait_active", 32'(irq_active), 1);
    pc_super  = 1'b1;
    irq_in[1] = 1'b0;
`ifdef IRQ_EDGE_EN
    irq_ack    = 1'b1;
    irq_ack_id = 2'd1;
`endif
    tick(1);
    irq_ack = 1'b0;
    chk("a_pending_after_service", 32'(irq_pending), 4'b0100);
    tick(1);
    chk("a_nested_no_take", 32'(irq_take), 0);
    pc_super = 1'b0;
    e0 = cyc;
    push(2, e0 + 2, 1);
    tick(1);
    chk("a_return_idle", 32'(irq_active), 0);
    chk("a_id_frozen", 32'(irq_id), 1);
    tick(1);
    tick(1);
    finish_handler(2);

    // Stalled take: high for 1 + 3 cycles, id frozen while ch0 arrives.
    irq_in = 4'b1000;
    stall  = 1'b1;
    e0 = cyc;
    push(3, e0 + 2, 4);
    tick(2);
    irq_in = 4'b1001;
    tick(2);
    chk("b_id_frozen", 32'(irq_id), 3);
    chk("b_take_stalled", 32'(irq_take), 1);
    tick(1);
    stall = 1'b0;
    tick(1);
    chk("b_take_released", 32'(irq_take), 0);
    finish_handler(3);
    push(0, cyc + 1, 1);
    tick(1);
    tick(1);
    finish_handler(0);

    // Mask blocks ch2 without clearing it; unmasking takes it two edges later.
    irq_mask_wr    = 1'b1;
    irq_mask_wdata = 4'b1011;
    tick(1);
    irq_mask_wr = 1'b0;
    chk("c_mask", 32'(irq_mask), 4'b1011);
    irq_in = 4'b0100;
    tick(4);
    chk("c_masked_no_take", 32'(irq_take), 0);
    chk("c_masked_pending", 32'(irq_pending), 4'b0100);
    irq_mask_wr    = 1'b1;
    irq_mask_wdata = 4'b1111;
    e0 = cyc;
    push(2, e0 + 2, 1);
    tick(1);
    irq_mask_wr = 1'b0;
    tick(1);
    tick(1);
    finish_handler(2);

    // Supervisor mode holds off the take until pc_super drops.
    pc_super = 1'b1;
    irq_in   = 4'b0001;
    tick(4);
    chk("d_super_no_take", 32'(irq_take), 0);
    chk("d_super_pending", 32'(irq_pending), 4'b0001);
    pc_super = 1'b0;
    push(0, cyc + 1, 1);
    tick(1);
    tick(1);
    finish_handler(0);

`ifdef IRQ_EDGE_EN
    pc_super   = 1'b1;
    irq_in     = 4'b1000;
    irq_ack    = 1'b1;
    irq_ack_id = 2'd3;
    tick(1);
    irq_ack = 1'b0;
    chk("e_set_beats_ack", 32'(irq_pending), 4'b1000);
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    chk("e_ack_clears", 32'(irq_pending), 4'b0000);
    irq_in   = '0;
    pc_super = 1'b0;
    tick(3);
    chk("e_idle", 32'(irq_active), 0);
`else
    pc_super   = 1'b1;
    irq_in     = 4'b0010;
    irq_ack    = 1'b1;
    irq_ack_id = 2'd1;
    tick(1);
    chk("l_ack_ignored", 32'(irq_pending), 4'b0010);
    irq_in  = '0;
    irq_ack = 1'b0;
    tick(1);
    chk("l_pending_follows", 32'(irq_pending), 4'b0000);
    pc_super = 1'b0;
    tick(3);
    chk("l_dropped_no_take", 32'(irq_take), 0);
`endif

    // Asynchronous reset in the middle of a stalled ISSUE.
    irq_mask_wr    = 1'b1;
    irq_mask_wdata = 4'b0010;
    tick(1);
    irq_mask_wr = 1'b0;
    stall       = 1'b1;
    irq_in      = 4'b0010;
    e0 = cyc;
    push(1, e0 + 2, 2);
    tick(4);
    chk("r_take_before", 32'(irq_take), 1);
    reset = 1'b1;
    #1;
    chk("r_take", 32'(irq_take), 0);
    chk("r_active", 32'(irq_active), 0);
    chk("r_id", 32'(irq_id), 0);
    chk("r_pending", 32'(irq_pending), 0);
    chk("r_mask", 32'(irq_mask), 4'b1111);
    irq_in = '0;
    stall  = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(3);

    chk("sb_empty", sb.size(), 0);
    chk("no_open_take", 32'(mon_in_take), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
